// File: rtl/irq_ctrl_pkg.sv
// Shared constants and helpers for the interrupt timer controller.
package irq_ctrl_pkg;

  localparam int N_CH_DEF  = 4;
  localparam int TMR_W_DEF = 16;

  // Handshake FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Index of the lowest set bit; channel vectors are zero-extended to the
  // 16-channel maximum before calling. Returns 0 for an all-zero vector.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/irq_timer_ch.sv
// One interrupt channel: rising-edge detect on the external line, a
// programmable countdown timer with optional auto-reload, and the pending flop.
module irq_timer_ch import irq_ctrl_pkg::*; #(
  parameter int TMR_W  = TMR_W_DEF,
  parameter int RELOAD = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,       // external line level; its rising edge raises an event
  input  logic             clear,     // acknowledge clear of the pending bit
  input  logic             load,      // timer load strobe
  input  logic [TMR_W-1:0] load_val,
  output logic             pending,
  output logic             fire       // an event sets pending at the coming edge
);

  logic             irq_q;
  logic [TMR_W-1:0] cnt;
  logic [TMR_W-1:0] rld;
  logic             rise;
  logic             tmr_fire;

  assign rise = set & ~irq_q;
  // A load on the expiring cycle restarts the count instead of firing.
  assign tmr_fire = ~load && (cnt == TMR_W'(1));
  assign fire = rise | tmr_fire;

  // Previous line level for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= set;
  end

  // Countdown timer; a load of 0 leaves it idle, expiry optionally reloads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      rld <= '0;
    end else if (load) begin
      cnt <= load_val;
      rld <= load_val;
    end else if (cnt != '0) begin
      if (tmr_fire && (RELOAD != 0) && (rld != '0)) cnt <= rld;
      else                                          cnt <= cnt - TMR_W'(1);
    end
  end

  // Pending flop; a new event on the same edge as a clear takes precedence
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= 1'b0;
    else        pending <= fire | (pending & ~clear);
  end

endmodule

// File: rtl/irq_timer_ctrl.sv
// Multi-channel interrupt source for the core's coprocessor-0 interrupt input:
// per-channel edge/timer events, masking, fixed priority (channel 0 highest)
// and a request/acknowledge handshake with a one-cycle low gap between requests.
module irq_timer_ctrl import irq_ctrl_pkg::*; #(
  parameter int N_CH   = N_CH_DEF,
  parameter int TMR_W  = TMR_W_DEF,
  parameter int ID_W   = 2,
  parameter int RELOAD = 0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [N_CH-1:0]  i_irq,
  input  logic [N_CH-1:0]  i_tmr_load,
  input  logic [TMR_W-1:0] i_tmr_val,
  input  logic             i_mask_we,
  input  logic [N_CH-1:0]  i_mask,
  input  logic             i_ack,
  output logic             o_irq,
  output logic [ID_W-1:0]  o_irq_id,
  output logic [N_CH-1:0]  o_pending
);

  logic [N_CH-1:0] pending;
  logic [N_CH-1:0] fire;
  logic [N_CH-1:0] clear;
  logic [N_CH-1:0] mask;
  logic [N_CH-1:0] active;
  logic [15:0]     active_ext;
  logic [1:0]      state;
  logic [ID_W-1:0] id;
  logic            irq;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    irq_timer_ch #(
      .TMR_W  (TMR_W),
      .RELOAD (RELOAD)
    ) u_ch (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .set      (i_irq[c]),
      .clear    (clear[c]),
      .load     (i_tmr_load[c]),
      .load_val (i_tmr_val),
      .pending  (pending[c]),
      .fire     (fire[c])
    );
  end

  // Mask register; only affects selection, never the pending bits
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       mask <= '0;
    else if (i_mask_we) mask <= i_mask;
  end

  // Eligible requests and the acknowledge clear of the presented channel;
  // the clear is withheld when a new event lands on the same edge.
  always_comb begin
    active     = pending & ~mask;
    active_ext = '0;
    active_ext[N_CH-1:0] = active;
    clear      = '0;
    if ((state == ST_REQ) && i_ack) clear[id] = ~fire[id];
  end

  // Handshake FSM: latch the winning id, hold it until ack, then one low cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      irq   <= 1'b0;
      id    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|active) begin
            id    <= ID_W'(lowest_set(active_ext));
            irq   <= 1'b1;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (i_ack) begin
            irq   <= 1'b0;
            state <= ST_GAP;
          end
        end
        ST_GAP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_irq     = irq;
  assign o_irq_id  = id;
  assign o_pending = pending;

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed bench for irq_timer_ctrl: one-shot instance (RELOAD=0) for most
// scenarios and a second auto-reload instance (RELOAD=1) for periodic timers.
module tb_irq_timer_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;

  logic [3:0]  irq, tmr_load, mask;
  logic [15:0] tmr_val;
  logic        mask_we, ack;
  logic        o_irq;
  logic [1:0]  o_irq_id;
  logic [3:0]  o_pending;

  logic [3:0]  r_irq, r_tmr_load, r_mask;
  logic [15:0] r_tmr_val;
  logic        r_mask_we, r_ack;
  logic        r_o_irq;
  logic [1:0]  r_o_irq_id;
  logic [3:0]  r_o_pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  irq_timer_ctrl #(.N_CH(4), .TMR_W(16), .ID_W(2), .RELOAD(0)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_irq      (irq),
    .i_tmr_load (tmr_load),
    .i_tmr_val  (tmr_val),
    .i_mask_we  (mask_we),
    .i_mask     (mask),
    .i_ack      (ack),
    .o_irq      (o_irq),
    .o_irq_id   (o_irq_id),
    .o_pending  (o_pending)
  );

  irq_timer_ctrl #(.N_CH(4), .TMR_W(16), .ID_W(2), .RELOAD(1)) dut_r (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_irq      (r_irq),
    .i_tmr_load (r_tmr_load),
    .i_tmr_val  (r_tmr_val),
    .i_mask_we  (r_mask_we),
    .i_mask     (r_mask),
    .i_ack      (r_ack),
    .o_irq      (r_o_irq),
    .o_irq_id   (r_o_irq_id),
    .o_pending  (r_o_pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expects a presentation of channel id, acks it, checks the drop and the gap.
  task automatic serve(input int id, input logic [3:0] pend_after);
    check("serve_irq", 32'(o_irq), 32'd1);
    check("serve_id", 32'(o_irq_id), 32'(id));
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_drop", 32'(o_irq), 32'd0);
    check("ack_pend", 32'(o_pending), 32'(pend_after));
    step();
    check("gap_low", 32'(o_irq), 32'd0);
  endtask

  initial begin
    int pres;
    logic bad;

    rst_n = 1'b0;
    irq = 4'hF; tmr_load = '0; tmr_val = '0; mask_we = 1'b0; mask = '0; ack = 1'b0;
    r_irq = '0; r_tmr_load = '0; r_tmr_val = '0; r_mask_we = 1'b0; r_mask = '0; r_ack = 1'b0;

    // Reset held for 3 cycles with all lines high
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_irq", 32'(o_irq), 32'd0);
      check("rst_pend", 32'(o_pending), 32'd0);
    end
    check("rst_id", 32'(o_irq_id), 32'd0);
    rst_n = 1'b1;
    step();
    check("rel_pend", 32'(o_pending), 32'hF);
    check("rel_irq", 32'(o_irq), 32'd0);
    irq = '0;
    step();
    serve(0, 4'b1110);
    step();
    serve(1, 4'b1100);
    step();
    serve(2, 4'b1000);
    step();
    serve(3, 4'b0000);

    // Single edge on channel 2, line held high afterwards
    irq = 4'b0100;
    step();
    check("edge_pend", 32'(o_pending), 32'h4);
    check("edge_irq0", 32'(o_irq), 32'd0);
    step();
    serve(2, 4'b0000);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (o_irq !== 1'b0 || o_pending !== 4'b0000) bad = 1'b1;
    end
    check("held_quiet", 32'(bad), 32'd0);
    irq = '0;

    // One-shot timer on channel 1, value 8
    tmr_val = 16'd8; tmr_load = 4'b0010;
    step();
    tmr_load = '0;
    repeat (7) step();
    check("os_early", 32'(o_pending), 32'h0);
    step();
    check("os_fire", 32'(o_pending), 32'h2);
    check("os_irq0", 32'(o_irq), 32'd0);
    step();
    serve(1, 4'b0000);
    bad = 1'b0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (o_irq !== 1'b0 || o_pending !== 4'b0000) bad = 1'b1;
    end
    check("os_quiet", 32'(bad), 32'd0);

    // Auto-reload timer on channel 0 of the RELOAD=1 instance, period 5
    r_tmr_val = 16'd5; r_tmr_load = 4'b0001;
    step();
    r_tmr_load = '0;
    pres = 0;
    for (int t = 1; t <= 31; t++) begin
      step();
      check("rl_irq", 32'(r_o_irq), ((t >= 6) && (t % 5 == 1)) ? 32'd1 : 32'd0);
      check("rl_pend", 32'(r_o_pending),
            ((t >= 5) && ((t % 5 == 0) || (t % 5 == 1))) ? 32'd1 : 32'd0);
      if (r_o_irq) begin
        pres++;
        check("rl_id", 32'(r_o_irq_id), 32'd0);
      end
      r_ack = r_o_irq;
    end
    r_ack = 1'b0;
    check("rl_count", 32'(pres), 32'd6);

    // Priority: channels 3 and 1 together
    irq = 4'b1010;
    step();
    check("pri_pend", 32'(o_pending), 32'hA);
    irq = '0;
    step();
    serve(1, 4'b1000);
    step();
    serve(3, 4'b0000);

    // Mask channel 1: only 3 is presented, 1 stays pending
    mask_we = 1'b1; mask = 4'b0010;
    step();
    mask_we = 1'b0;
    irq = 4'b1010;
    step();
    check("msk_pend", 32'(o_pending), 32'hA);
    irq = '0;
    step();
    serve(3, 4'b0010);
    repeat (3) step();
    check("msk_hold_irq", 32'(o_irq), 32'd0);
    check("msk_hold_pend", 32'(o_pending), 32'h2);
    mask_we = 1'b1; mask = 4'b0000;
    step();
    mask_we = 1'b0;
    check("unmsk_wait", 32'(o_irq), 32'd0);
    step();
    serve(1, 4'b0000);

    // Ack collides with a new rising edge on the same channel
    irq = 4'b0100;
    step();
    step();
    check("col_irq", 32'(o_irq), 32'd1);
    check("col_id", 32'(o_irq_id), 32'd2);
    irq = 4'b0000;
    step();
    check("col_hold", 32'(o_irq), 32'd1);
    irq = 4'b0100; ack = 1'b1;
    step();
    ack = 1'b0;
    check("col_pend", 32'(o_pending), 32'h4);
    check("col_drop", 32'(o_irq), 32'd0);
    step();
    check("col_gap", 32'(o_irq), 32'd0);
    step();
    serve(2, 4'b0000);

    // Asynchronous reset while a request is presented
    irq = 4'b1100;
    step();
    step();
    check("ar_irq", 32'(o_irq), 32'd1);
    check("ar_id", 32'(o_irq_id), 32'd3);
    rst_n = 1'b0;
    #1;
    check("ar_drop", 32'(o_irq), 32'd0);
    check("ar_pend", 32'(o_pending), 32'd0);
    check("ar_id0", 32'(o_irq_id), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
